// File: rtl/lcd_pkg.sv
// Shared types and constants for the HD44780 display controller.
// State encoding, panel command bytes and the opcode-to-mnemonic ROM.
package lcd_pkg;

    typedef enum logic [2:0] {
        PWR_WAIT, INIT, IDLE, CONVERT, ADDR1, LINE1, ADDR2, LINE2
    } lcd_state_e;

    localparam logic [7:0] LCD_FUNC_SET = 8'h38;
    localparam logic [7:0] LCD_DISP_ON  = 8'h0C;
    localparam logic [7:0] LCD_ENTRY    = 8'h06;
    localparam logic [7:0] LCD_CLEAR    = 8'h01;
    localparam logic [7:0] LCD_LINE1    = 8'h80;
    localparam logic [7:0] LCD_LINE2    = 8'hC0;

    localparam logic [7:0] CHAR_SPACE = 8'h20;
    localparam logic [7:0] CHAR_PLUS  = 8'h2B;
    localparam logic [7:0] CHAR_MINUS = 8'h2D;

    function automatic logic [31:0] mnemonic(input logic [2:0] op);
        case (op)
            3'd0:    return "LOAD";
            3'd1:    return "ADD ";
            3'd2:    return "ADDI";
            3'd3:    return "SUB ";
            3'd4:    return "SUBI";
            3'd5:    return "MUL ";
            3'd6:    return "CLR ";
            default: return "DPL ";
        endcase
    endfunction

    function automatic logic [7:0] init_cmd(input logic [1:0] i);
        case (i)
            2'd0:    return LCD_FUNC_SET;
            2'd1:    return LCD_DISP_ON;
            2'd2:    return LCD_ENTRY;
            default: return LCD_CLEAR;
        endcase
    endfunction

    function automatic logic is_write(input lcd_state_e s);
        return s inside {INIT, ADDR1, LINE1, ADDR2, LINE2};
    endfunction

endpackage

// File: rtl/lcd_bin2bcd.sv
// Sequential double-dabble: one load cycle on start, then 16 shift-add steps.
// done pulses for one cycle; digits hold until the next start.
module lcd_bin2bcd (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [15:0]     bin,
    output logic            done,
    output logic [4:0][3:0] digits
);

    logic [15:0]     sh;
    logic [4:0][3:0] bcd, adj;
    logic [3:0]      step;
    logic            busy;

    always_comb begin
        adj = '0;
        for (int i = 0; i < 5; i++)
            adj[i] = (bcd[i] >= 4'd5) ? bcd[i] + 4'd3 : bcd[i];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh   <= '0;
            bcd  <= '0;
            step <= '0;
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                sh   <= bin;
                bcd  <= '0;
                step <= '0;
                busy <= 1'b1;
            end else if (busy) begin
                {bcd, sh} <= {adj, sh} << 1;
                step      <= step + 4'd1;
                if (step == 4'd15) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end

    assign digits = bcd;

endmodule

// File: rtl/lcd_display_ctrl.sv
// 16x2 character LCD driver: power-up init, then mnemonic on line 1 and decimal result on line 2.
// Define LCD_SIGNED_EN to treat result as two's complement with a +/- sign column.
module lcd_display_ctrl
    import lcd_pkg::*;
#(
    parameter int POWERUP_CYC    = 750000,
    parameter int E_PULSE_CYC    = 12,
    parameter int CMD_WAIT_CYC   = 2000,
    parameter int CLEAR_WAIT_CYC = 82000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        upd_valid,
    output logic        upd_ready,
    input  logic [2:0]  opcode,
    input  logic [15:0] result,
    output logic        init_done,
    output logic [7:0]  lcd_data,
    output logic        lcd_rs,
    output logic        lcd_rw,
    output logic        lcd_e
);

    localparam int WR_NORM  = 1 + E_PULSE_CYC + CMD_WAIT_CYC;
    localparam int WR_CLEAR = 1 + E_PULSE_CYC + CLEAR_WAIT_CYC;
    localparam int MAX_CYC  = (POWERUP_CYC > WR_CLEAR) ? POWERUP_CYC : WR_CLEAR;
    localparam int CW       = $clog2(MAX_CYC + 1);

    lcd_state_e      state, state_nxt;
    logic [CW-1:0]   cnt, cnt_nxt;
    logic [3:0]      idx, idx_nxt;
    logic [2:0]      op_q;
    logic [15:0]     res_q, mag;
    logic            init_nxt, accept, start_q, bcd_done, wr_last, e_nxt;
    logic [4:0][3:0] digits;
    logic [31:0]     mn;
    logic [7:0]      sign_char, line1_char, line2_char;

`ifdef LCD_SIGNED_EN
    // Negating 0x8000 wraps back to 0x8000, which is exactly the 32768 magnitude we want.
    assign mag       = res_q[15] ? -res_q : res_q;
    assign sign_char = res_q[15] ? CHAR_MINUS : CHAR_PLUS;
`else
    assign mag       = res_q;
    assign sign_char = CHAR_SPACE;
`endif

    lcd_bin2bcd u_bcd (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start_q),
        .bin    (mag),
        .done   (bcd_done),
        .digits (digits)
    );

    always_comb begin
        mn         = mnemonic(op_q);
        line1_char = CHAR_SPACE;
        case (idx)
            4'd0:    line1_char = mn[31:24];
            4'd1:    line1_char = mn[23:16];
            4'd2:    line1_char = mn[15:8];
            4'd3:    line1_char = mn[7:0];
            default: ;
        endcase
        line2_char = CHAR_SPACE;
        case (idx)
            4'd0:    line2_char = sign_char;
            4'd1:    line2_char = {4'h3, digits[4]};
            4'd2:    line2_char = {4'h3, digits[3]};
            4'd3:    line2_char = {4'h3, digits[2]};
            4'd4:    line2_char = {4'h3, digits[1]};
            4'd5:    line2_char = {4'h3, digits[0]};
            default: ;
        endcase
    end

    // Bus byte depends only on state/idx, so it is stable across each write window.
    always_comb begin
        lcd_data = 8'h00;
        lcd_rs   = 1'b0;
        case (state)
            INIT:    lcd_data = init_cmd(idx[1:0]);
            ADDR1:   lcd_data = LCD_LINE1;
            LINE1:   begin lcd_data = line1_char; lcd_rs = 1'b1; end
            ADDR2:   lcd_data = LCD_LINE2;
            LINE2:   begin lcd_data = line2_char; lcd_rs = 1'b1; end
            default: ;
        endcase
    end

    assign lcd_rw    = 1'b0;
    assign upd_ready = (state == IDLE);
    assign wr_last   = (cnt == ((!lcd_rs && lcd_data == LCD_CLEAR) ? CW'(WR_CLEAR - 1)
                                                                    : CW'(WR_NORM - 1)));

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt + 1'b1;
        idx_nxt   = idx;
        init_nxt  = init_done;
        accept    = 1'b0;
        case (state)
            PWR_WAIT: if (cnt == CW'(POWERUP_CYC - 1)) begin
                state_nxt = INIT;
                cnt_nxt   = '0;
            end
            IDLE: begin
                cnt_nxt = '0;
                if (upd_valid) begin
                    accept    = 1'b1;
                    state_nxt = CONVERT;
                end
            end
            CONVERT: begin
                cnt_nxt = '0;
                if (bcd_done) state_nxt = ADDR1;
            end
            default: if (wr_last) begin
                cnt_nxt = '0;
                idx_nxt = idx + 4'd1;
                case (state)
                    INIT:    if (idx == 4'd3) begin
                                 state_nxt = IDLE;
                                 idx_nxt   = '0;
                                 init_nxt  = 1'b1;
                             end
                    ADDR1:   begin state_nxt = LINE1; idx_nxt = '0; end
                    LINE1:   if (idx == 4'd15) state_nxt = ADDR2;
                    ADDR2:   begin state_nxt = LINE2; idx_nxt = '0; end
                    LINE2:   if (idx == 4'd15) state_nxt = IDLE;
                    default: ;
                endcase
            end
        endcase
        // Strobe is registered from next-state so it never glitches.
        e_nxt = is_write(state_nxt) && (cnt_nxt >= CW'(1)) && (cnt_nxt <= CW'(E_PULSE_CYC));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= PWR_WAIT;
            cnt       <= '0;
            idx       <= '0;
            op_q      <= '0;
            res_q     <= '0;
            init_done <= 1'b0;
            start_q   <= 1'b0;
            lcd_e     <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            idx       <= idx_nxt;
            init_done <= init_nxt;
            start_q   <= accept;
            lcd_e     <= e_nxt;
            if (accept) begin
                op_q  <= opcode;
                res_q <= result;
            end
        end
    end

endmodule

// File: tb/tb_lcd_display_ctrl.sv
// Randomized bench for lcd_display_ctrl: captures every bus write on the lcd_e rising edge
// and compares it with a string-level model of what the panel should show.
module tb_lcd_display_ctrl;

    logic        clk = 1'b0;
    logic        rst_n, upd_valid, upd_ready, init_done;
    logic [2:0]  opcode;
    logic [15:0] result;
    logic [7:0]  lcd_data;
    logic        lcd_rs, lcd_rw, lcd_e;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int rel;

    logic [8:0] bus_q[$];
    int         t_q[$];
    logic       e_prev = 1'b0;
    logic [8:0] last_w = '0;

    string mn_tab[8] = '{"LOAD", "ADD ", "ADDI", "SUB ", "SUBI", "MUL ", "CLR ", "DPL "};
    int    init_exp[4] = '{'h038, 'h00C, 'h006, 'h001};

    lcd_display_ctrl #(
        .POWERUP_CYC    (20),
        .E_PULSE_CYC    (2),
        .CMD_WAIT_CYC   (4),
        .CLEAR_WAIT_CYC (10)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .upd_valid (upd_valid),
        .upd_ready (upd_ready),
        .opcode    (opcode),
        .result    (result),
        .init_done (init_done),
        .lcd_data  (lcd_data),
        .lcd_rs    (lcd_rs),
        .lcd_rw    (lcd_rw),
        .lcd_e     (lcd_e)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Bus monitor: one entry per strobe, data must hold while the strobe is high.
    always @(negedge clk) begin
        if (lcd_e && !e_prev) begin
            bus_q.push_back({lcd_rs, lcd_data});
            t_q.push_back(cyc);
            last_w = {lcd_rs, lcd_data};
        end else if (lcd_e && e_prev) begin
            chk("bus_stable", int'({lcd_rs, lcd_data}), int'(last_w));
        end
        e_prev = lcd_e;
    end

    function automatic int exp_word(input logic [2:0] op, input logic [15:0] r, input int i);
        int mag, sgn, j, p;
        mag = int'(r);
        sgn = 32;
`ifdef LCD_SIGNED_EN
        if (r[15]) begin mag = 65536 - int'(r); sgn = 45; end
        else sgn = 43;
`endif
        if (i == 0) return 'h080;
        if (i <= 16) begin
            j = i - 1;
            return (j < 4) ? ('h100 | int'(mn_tab[op][j])) : 'h120;
        end
        if (i == 17) return 'h0C0;
        j = i - 18;
        if (j == 0) return 'h100 | sgn;
        if (j <= 5) begin
            p = 1;
            for (int k = j; k < 5; k++) p = p * 10;
            return 'h100 | (48 + (mag / p) % 10);
        end
        return 'h120;
    endfunction

    task automatic step();
        @(negedge clk);
        #2;
    endtask

    task automatic wait_ready(input int max);
        int n = 0;
        while (!upd_ready && n < max) begin step(); n++; end
        if (!upd_ready) chk("ready_timeout", 0, 1);
    endtask

    task automatic init_seq();
        int n = 0;
        @(posedge clk);
        bus_q.delete();
        t_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        rel   = cyc;
        while (bus_q.size() < 4 && n < 200) begin step(); n++; end
        chk("init_writes", bus_q.size() >= 4, 1);
        if (bus_q.size() >= 4) begin
            chk("pwr_wait", t_q[0] - rel, 21);
            for (int i = 0; i < 4; i++) chk("init_cmd", int'(bus_q[i]), init_exp[i]);
            for (int i = 1; i < 4; i++) chk("init_gap", t_q[i] - t_q[i-1], 7);
            wait_ready(100);
            chk("clear_wait", cyc - t_q[3], 12);
            chk("init_done", int'(init_done), 1);
            chk("init_count", bus_q.size(), 4);
        end
    endtask

    task automatic send(input logic [2:0] op, input logic [15:0] r, output int c0);
        wait_ready(1000);
        upd_valid = 1'b1;
        opcode    = op;
        result    = r;
        @(posedge clk);
        #1;
        c0        = cyc;
        upd_valid = 1'b0;
        opcode    = 3'($urandom);
        result    = 16'($urandom);
    endtask

    task automatic check_update(input logic [2:0] op, input logic [15:0] r, input int c0);
        wait_ready(600);
        chk("upd_latency", cyc - c0, 256);
        chk("write_count", bus_q.size(), 34);
        for (int i = 0; i < 34 && i < bus_q.size(); i++)
            chk($sformatf("write%0d_op%0d_r%0d", i, op, r), int'(bus_q[i]), exp_word(op, r, i));
        for (int i = 1; i < bus_q.size(); i++) chk("write_gap", t_q[i] - t_q[i-1], 7);
    endtask

    task automatic run_one(input logic [2:0] op, input logic [15:0] r);
        int c0;
        bus_q.delete();
        t_q.delete();
        send(op, r, c0);
        check_update(op, r, c0);
    endtask

    initial begin
        int c0, n;
        logic [2:0]  op;
        logic [15:0] r;
        rst_n = 1'b0; upd_valid = 1'b0; opcode = '0; result = '0;
        repeat (3) step();
        chk("reset_outs", int'({lcd_e, lcd_rs, lcd_rw, upd_ready, init_done, lcd_data}), 0);
        init_seq();

        run_one(3'd1, 16'd1234);
`ifdef LCD_SIGNED_EN
        run_one(3'd5, 16'h8000);
        run_one(3'd3, 16'hFFFF);
`else
        run_one(3'd5, 16'hFFFF);
`endif
        run_one(3'd6, 16'd0);
        repeat (6) run_one(3'($urandom_range(0, 7)), 16'($urandom_range(0, 65535)));

        // Update offered while busy must be dropped, not queued.
        bus_q.delete();
        t_q.delete();
        send(3'd2, 16'd4321, c0);
        n = 0;
        while (bus_q.size() < 8 && n < 300) begin step(); n++; end
        upd_valid = 1'b1; opcode = 3'd7; result = 16'd999;
        repeat (3) step();
        upd_valid = 1'b0;
        check_update(3'd2, 16'd4321, c0);
        repeat (60) step();
        chk("no_second_update", bus_q.size(), 34);
        chk("ready_hold", int'(upd_ready), 1);

        // Asynchronous reset in the middle of line 2.
        op = 3'($urandom_range(0, 7));
        r  = 16'($urandom_range(0, 65535));
        bus_q.delete();
        t_q.delete();
        send(op, r, c0);
        n = 0;
        while (bus_q.size() < 25 && n < 400) begin step(); n++; end
        chk("reached_line2", bus_q.size() >= 25, 1);
        step();
        #1 rst_n = 1'b0;
        #1 chk("async_reset", int'({lcd_e, lcd_rs, lcd_rw, upd_ready, init_done, lcd_data}), 0);
        init_seq();
        run_one(3'($urandom_range(0, 7)), 16'($urandom_range(0, 65535)));
        chk("rw_low", int'(lcd_rw), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
